// File: rtl/bpi_pkg.sv
// Shared encodings and default timing constants for the BPI configuration reader.
package bpi_pkg;
  localparam int ADDR_W = 23;
  localparam int DQ_W   = 16;
  localparam int TMR_W  = 9;

  localparam int          DEF_BLOCK_WORDS  = 128;
  localparam int          DEF_ACC_CYCLES   = 8;
  localparam int          DEF_DRAIN_CYCLES = 300;
  localparam logic [15:0] DEF_MAX_BLOCKS   = 16'd4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_CAPTURE,
    S_GAP,
    S_DRAIN
  } state_t;

  // Chip/output enable are asserted only while a word access is in flight.
  function automatic logic bus_active(input state_t s);
    return (s == S_SETUP) || (s == S_ACCESS) || (s == S_CAPTURE);
  endfunction
endpackage

// File: rtl/bpi_timer.sv
// Loadable down-counter with expiry flag; shared by flash access and drain waits.
module bpi_timer import bpi_pkg::*; #(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/bpi_cfg_reader.sv
// Reads 256-byte reconfiguration records from parallel NOR flash one word at a
// time, pacing strobes for a byte-wide consumer and draining between blocks.
module bpi_cfg_reader import bpi_pkg::*; #(
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 23'h000000,
  parameter int                BLOCK_WORDS  = DEF_BLOCK_WORDS,
  parameter int                ACC_CYCLES   = DEF_ACC_CYCLES,
  parameter int                DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter logic [15:0]       MAX_BLOCKS   = DEF_MAX_BLOCKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reconfig_read_start,
  input  logic              reconfig_read_end,
  input  logic [DQ_W-1:0]   flash_dq,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  output logic [DQ_W-1:0]   reconfig_data,
  output logic              reconfig_data_en,
  output logic              bpi_idle,
  output logic              read_done,
  output logic              read_overrun
);
  localparam logic [TMR_W-1:0] ACC_LOAD   = TMR_W'(ACC_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);
  localparam logic [7:0]       LAST_WORD  = 8'(BLOCK_WORDS - 1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] addr;
  logic              addr_wrap;
  logic [7:0]        word_cnt;
  logic [15:0]       blk_cnt;
  logic              end_seen;

  logic              tmr_load, tmr_dec, tmr_exp;
  logic [TMR_W-1:0]  tmr_val;
  logic              set_ovr;
  logic              end_any;
  logic              last_word;

  assign end_any    = end_seen | reconfig_read_end;
  assign last_word  = (word_cnt == LAST_WORD);
  assign flash_addr = addr;
  assign flash_we_n = 1'b1;

  bpi_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expired  (tmr_exp)
  );

  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    set_ovr  = 1'b0;
    case (state)
      S_IDLE:    if (reconfig_read_start) nxt = S_SETUP;
      S_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = ACC_LOAD;
        nxt      = S_ACCESS;
      end
      S_ACCESS: begin
        if (tmr_exp) nxt = S_CAPTURE;
        else         tmr_dec = 1'b1;
      end
      S_CAPTURE: nxt = S_GAP;
      S_GAP: begin
        // An abort finishes the word in flight, then leaves after a 1-cycle drain.
        if (end_any) begin
          nxt      = S_DRAIN;
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else if (last_word) begin
          nxt      = S_DRAIN;
          tmr_load = 1'b1;
          tmr_val  = DRAIN_LOAD;
        end else begin
          nxt = S_SETUP;
        end
      end
      S_DRAIN: begin
        if (tmr_exp) begin
          if (end_any) begin
            nxt = S_IDLE;
          end else if (blk_cnt == MAX_BLOCKS || addr_wrap) begin
            set_ovr = 1'b1;
            nxt     = S_IDLE;
          end else begin
            nxt = S_SETUP;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      addr             <= '0;
      addr_wrap        <= 1'b0;
      word_cnt         <= '0;
      blk_cnt          <= '0;
      end_seen         <= 1'b0;
      flash_ce_n       <= 1'b1;
      flash_oe_n       <= 1'b1;
      reconfig_data    <= '0;
      reconfig_data_en <= 1'b0;
      bpi_idle         <= 1'b1;
      read_done        <= 1'b0;
      read_overrun     <= 1'b0;
    end else begin
      state            <= nxt;
      reconfig_data_en <= 1'b0;
      read_done        <= 1'b0;
      flash_ce_n       <= !bus_active(nxt);
      flash_oe_n       <= !bus_active(nxt);
      bpi_idle         <= (nxt == S_IDLE) || (nxt == S_DRAIN);

      // A start while idle wins over a coincident end.
      if (state == S_IDLE && reconfig_read_start) begin
        addr         <= BASE_ADDR;
        addr_wrap    <= 1'b0;
        word_cnt     <= '0;
        blk_cnt      <= '0;
        end_seen     <= 1'b0;
        read_overrun <= 1'b0;
      end else if (state != S_IDLE && reconfig_read_end) begin
        end_seen <= 1'b1;
      end

      if (state == S_CAPTURE) begin
        reconfig_data    <= flash_dq;
        reconfig_data_en <= 1'b1;
        addr             <= addr + 1'b1;
        if (addr == '1) addr_wrap <= 1'b1;
      end

      if (state == S_GAP) begin
        if (last_word) begin
          word_cnt <= '0;
          blk_cnt  <= blk_cnt + 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end

      if (set_ovr) read_overrun <= 1'b1;
      if (state == S_DRAIN && nxt == S_IDLE) read_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bpi_cfg_reader.sv
// Directed bench: flash model returns addr[15:0]; checks pacing, drain, abort,
// overrun and asynchronous reset behaviour.
module tb_bpi_cfg_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, end1 = 1'b0;
  logic [15:0] dq1, data1;
  logic [22:0] addr1;
  logic        ce1, oe1, we1, en1, idle1, done1, ovr1;

  logic        start2 = 1'b0, end2 = 1'b0;
  logic [15:0] dq2, data2;
  logic [22:0] addr2;
  logic        ce2, oe2, we2, en2, idle2, done2, ovr2;

  assign dq1 = (!ce1 && !oe1) ? addr1[15:0] : 16'hFFFF;
  assign dq2 = (!ce2 && !oe2) ? addr2[15:0] : 16'hFFFF;

  bpi_cfg_reader dut (
    .clk(clk), .rst(rst), .reconfig_read_start(start1), .reconfig_read_end(end1),
    .flash_dq(dq1), .flash_addr(addr1), .flash_ce_n(ce1), .flash_oe_n(oe1),
    .flash_we_n(we1), .reconfig_data(data1), .reconfig_data_en(en1),
    .bpi_idle(idle1), .read_done(done1), .read_overrun(ovr1)
  );

  bpi_cfg_reader #(.MAX_BLOCKS(16'd2)) dut2 (
    .clk(clk), .rst(rst), .reconfig_read_start(start2), .reconfig_read_end(end2),
    .flash_dq(dq2), .flash_addr(addr2), .flash_ce_n(ce2), .flash_oe_n(oe2),
    .flash_we_n(we2), .reconfig_data(data2), .reconfig_data_en(en2),
    .bpi_idle(idle2), .read_done(done2), .read_overrun(ovr2)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] q1[$];
  int          t1[$];
  int          nd1 = 0, td1 = 0;
  logic [15:0] q2[$];
  int          nd2 = 0;

  always @(negedge clk) begin
    if (en1) begin q1.push_back(data1); t1.push_back(cyc); end
    if (done1) begin nd1++; td1 = cyc; end
    if (en2) q2.push_back(data2);
    if (done2) nd2++;
  end

  initial begin
    int t0, base, err, n;

    // reset values
    #2 rst = 1'b0;
    #1;
    check("rst_addr",  32'(addr1), 32'h0);
    check("rst_ce_n",  32'(ce1),   32'h1);
    check("rst_oe_n",  32'(oe1),   32'h1);
    check("rst_we_n",  32'(we1),   32'h1);
    check("rst_data",  32'(data1), 32'h0);
    check("rst_en",    32'(en1),   32'h0);
    check("rst_idle",  32'(idle1), 32'h1);
    check("rst_done",  32'(done1), 32'h0);
    check("rst_ovr",   32'(ovr1),  32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // MAX_BLOCKS=2 without end: two full blocks then overrun
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 6000 && nd2 == 0; i++) begin @(negedge clk); #1; end
    check("ovr_done_seen", 32'(nd2), 32'd1);
    check("ovr_strobes",   32'(q2.size()), 32'd256);
    check("ovr_flag",      32'(ovr2), 32'h1);
    check("ovr_data128",   32'(q2.size() > 128 ? q2[128] : 16'hDEAD), 32'h80);
    check("ovr_data255",   32'(q2.size() > 255 ? q2[255] : 16'hDEAD), 32'hFF);
    @(negedge clk); #1;
    check("ovr_done_width", 32'(done2), 32'h0);
    check("ovr_sticky",     32'(ovr2),  32'h1);
    check("ovr_idle",       32'(idle2), 32'h1);

    // normal session, with a stray start during the first ACCESS
    @(negedge clk); start1 = 1'b1; t0 = cyc;
    @(negedge clk); start1 = 1'b0;
    repeat (3) @(negedge clk); #1;
    check("acc_ce_n", 32'(ce1),   32'h0);
    check("acc_oe_n", 32'(oe1),   32'h0);
    check("acc_idle", 32'(idle1), 32'h0);
    check("acc_addr", 32'(addr1), 32'h0);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 2000 && q1.size() < 128; i++) begin @(negedge clk); #1; end
    check("blk0_count", 32'(q1.size() >= 128), 32'h1);
    if (q1.size() >= 128) begin
      check("first_latency", 32'(t1[0] - t0), 32'd11);
      err = 0;
      for (int i = 0; i < 128; i++) if (q1[i] !== 16'(i)) err++;
      check("blk0_data", 32'(err), 32'd0);
      err = 0;
      for (int i = 1; i < 128; i++) if (t1[i] - t1[i-1] != 11) err++;
      check("blk0_spacing", 32'(err), 32'd0);
      check("blk0_last", 32'(q1[127]), 32'h7F);
    end
    repeat (5) @(negedge clk); #1;
    check("drain_idle", 32'(idle1), 32'h1);
    check("drain_ce_n", 32'(ce1),   32'h1);
    for (int i = 0; i < 400 && q1.size() < 129; i++) begin @(negedge clk); #1; end
    check("blk1_count", 32'(q1.size() >= 129), 32'h1);
    if (q1.size() >= 129) begin
      check("blk1_first", 32'(q1[128]), 32'h80);
      check("drain_gap",  32'(t1[128] - t1[127]), 32'd311);
    end

    // end pulse during the drain following block 3
    for (int i = 0; i < 3500 && q1.size() < 384; i++) begin @(negedge clk); #1; end
    check("blk2_count", 32'(q1.size()), 32'd384);
    repeat (10) @(negedge clk);
    end1 = 1'b1;
    @(negedge clk); end1 = 1'b0;
    for (int i = 0; i < 400 && nd1 == 0; i++) begin @(negedge clk); #1; end
    check("drn_end_done", 32'(nd1), 32'd1);
    if (q1.size() >= 384) check("drn_end_time", 32'(td1 - t1[383]), 32'd301);
    check("drn_end_idle", 32'(idle1), 32'h1);
    @(negedge clk); #1;
    check("drn_done_width", 32'(done1), 32'h0);
    repeat (30) @(negedge clk); #1;
    check("drn_no_strobe", 32'(q1.size()), 32'd384);
    check("drn_idle_hold", 32'(idle1), 32'h1);
    check("drn_no_ovr",    32'(ovr1),  32'h0);
    check("drn_blk_cnt",   32'(dut.blk_cnt), 32'd3);

    // end pulse right after word 40 of a fresh session
    base = q1.size();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 600 && q1.size() < base + 41; i++) begin @(negedge clk); #1; end
    end1 = 1'b1;
    @(negedge clk); end1 = 1'b0;
    check("ab_count41", 32'(q1.size()), 32'(base + 41));
    n = (q1.size() > base + 40) ? t1[base + 40] : 0;
    for (int i = 0; i < 20 && nd1 < 2; i++) begin @(negedge clk); #1; end
    check("ab_done", 32'(nd1), 32'd2);
    check("ab_done_fast", 32'((td1 - n) <= 3 && (td1 - n) > 0), 32'h1);
    if (q1.size() > base + 40) check("ab_word40", 32'(q1[base + 40]), 32'h28);
    repeat (30) @(negedge clk); #1;
    check("ab_no_strobe", 32'(q1.size()), 32'(base + 41));
    check("ab_ce_n", 32'(ce1),   32'h1);
    check("ab_idle", 32'(idle1), 32'h1);
    check("ab_ovr",  32'(ovr1),  32'h0);

    // asynchronous reset during ACCESS of word 5
    base = q1.size();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 200 && q1.size() < base + 5; i++) begin @(negedge clk); #1; end
    repeat (4) @(negedge clk); #1;
    check("ar_pre_ce_n", 32'(ce1),   32'h0);
    check("ar_pre_addr", 32'(addr1), 32'h5);
    n = nd1;
    #2 rst = 1'b0;
    #1;
    check("ar_ce_n", 32'(ce1),   32'h1);
    check("ar_oe_n", 32'(oe1),   32'h1);
    check("ar_idle", 32'(idle1), 32'h1);
    check("ar_addr", 32'(addr1), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk); #1;
    check("ar_no_done", 32'(nd1), 32'(n));
    check("ar_still_idle", 32'(idle1), 32'h1);
    base = q1.size();
    @(negedge clk); start1 = 1'b1; t0 = cyc;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 100 && q1.size() < base + 1; i++) begin @(negedge clk); #1; end
    check("ar_restart_cnt", 32'(q1.size()), 32'(base + 1));
    if (q1.size() > base) begin
      check("ar_restart_data", 32'(q1[base]), 32'h0);
      check("ar_restart_lat",  32'(t1[base] - t0), 32'd11);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/bpi_cfg_reader.md
BPI_CFG_READER -- requirements
Module: bpi_cfg_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 23'h000000: first flash word address of the reconfiguration record area.
REQ-002 SHALL have parameter BLOCK_WORDS, default 128: words per block (one 256-byte command).
REQ-003 SHALL have parameter ACC_CYCLES, default 8: clk cycles from address/OE valid to data sample, legal range 2..255.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 300: idle cycles between blocks so the consumer can drain 256 bytes, minimum 264.
REQ-005 SHALL have parameter MAX_BLOCKS, default 16'd4096: block limit per session.
REQ-006 Ports; one clock; reset is asynchronous and active-low:
 clk  in  1  system clock
 rst  in  1  asynchronous active-low reset
 reconfig_read_start  in  1  one-cycle pulse, start a read session
 reconfig_read_end  in  1  one-cycle pulse, consumer found the last record, stop
 flash_dq  in  16  flash data bus
 flash_addr  out  23  flash word address
 flash_ce_n  out  1  chip enable, active low
 flash_oe_n  out  1  output enable, active low
 flash_we_n  out  1  write enable, constant 1
 reconfig_data  out  16  captured flash word
 reconfig_data_en  out  1  one-cycle strobe qualifying reconfig_data
 bpi_idle  out  1  high when the flash bus is not being driven
 read_done  out  1  one-cycle pulse, session ended
 read_overrun  out  1  sticky, MAX_BLOCKS or address top reached without reconfig_read_end

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, ACCESS, CAPTURE, GAP, DRAIN.
REQ-008 IDLE: on reconfig_read_start, load addr=BASE_ADDR, word_cnt=0, blk_cnt=0, clear end_seen and read_overrun, go to SETUP. Any other input SHALL be ignored.
REQ-009 SETUP: drive flash_addr, flash_ce_n=0, flash_oe_n=0, clear the access timer, then go to ACCESS.
REQ-010 ACCESS: hold the bus for ACC_CYCLES cycles, then go to CAPTURE.
REQ-011 CAPTURE: register flash_dq into reconfig_data, pulse reconfig_data_en for exactly 1 cycle, increment addr, then go to GAP.
REQ-012 GAP: deassert ce_n/oe_n for one cycle. Two reconfig_data_en pulses SHALL therefore never be closer than ACC_CYCLES+3 cycles (at least 5), because the consumer splits each word over 2 cycles.
REQ-013 After the last word of a block (word_cnt=BLOCK_WORDS-1), GAP SHALL go to DRAIN, increment blk_cnt, and reset word_cnt. Otherwise it SHALL increment word_cnt and go to SETUP.
REQ-014 DRAIN: bpi_idle=1; wait DRAIN_CYCLES. On expiry:
 - end_seen set: go to IDLE.
 - else blk_cnt==MAX_BLOCKS or addr wrapped past 23'h7FFFFF: set read_overrun, go to IDLE.
 - else: go to SETUP.
REQ-015 reconfig_read_end SHALL set end_seen in any non-IDLE state. In SETUP/ACCESS/CAPTURE/GAP it SHALL abort after the current GAP and go to DRAIN with the timer preloaded to expire next cycle; no further data_en after the abort.
REQ-016 read_done SHALL pulse 1 cycle on every transition into IDLE from DRAIN.
REQ-017 bpi_idle SHALL be 1 in IDLE and DRAIN and 0 otherwise, registered, changing on the same edge as the state.
REQ-018 reconfig_read_start while not in IDLE SHALL be ignored. Simultaneous start and end in IDLE: start wins, end ignored.
REQ-019 addr SHALL be 23 bits wide; increment modulo 2^23 with a wrap flag; blk_cnt 16 bits; word_cnt 8 bits; access and drain timers 9 bits.

Reset
REQ-020 On rst=0 (asynchronous), all outputs SHALL take reset values immediately: flash_addr=0, flash_ce_n=1, flash_oe_n=1, flash_we_n=1, reconfig_data=0, reconfig_data_en=0, bpi_idle=1, read_done=0, read_overrun=0; state=IDLE.
REQ-021 Reset mid-session SHALL abandon the session with no read_done; release on a clock edge only.

Structure
REQ-022 State encodings and the default timing constants SHALL live in shared package bpi_pkg.
REQ-023 A single sub-module bpi_timer (loadable down-counter with expiry flag) SHALL serve ACCESS and DRAIN.

Verification
REQ-024 Start, flash model returns addr[15:0]: 128 strobes; data 0x0000..0x007F; strobe spacing 11 cycles; DRAIN 300 cycles; then 2nd block 0x0080.
REQ-025 reconfig_read_end during DRAIN of block 3: no further strobes, read_done 1 cycle at timer expiry, bpi_idle stays 1, blk_cnt=3.
REQ-026 reconfig_read_end at word 40 of block 1: strobes stop after word 40, read_done within 3 cycles, ce_n=1.
REQ-027 MAX_BLOCKS=2 with no end: 256 strobes total, read_overrun=1, read_done pulses.
REQ-028 rst low in ACCESS: ce_n/oe_n go to 1 within the same cycle (asynchronously), bpi_idle=1, no read_done; a fresh start restarts at BASE_ADDR.
REQ-029 Start pulse while in ACCESS: ignored, address sequence unchanged.
